// File: rtl/debug_dump_engine_if.sv
// debug_dump_engine_if: bundles the two handshakes the dump engine drives.
//   Debug read side : addr (engine -> MIPS), regs / mem_datos (MIPS -> engine,
//                     synchronous read, one cycle of latency).
//   UART TX side    : tx_start / uart_data_out (engine -> UART),
//                     tx_done (UART -> engine, byte-complete pulse).
// master = the dump engine, slave = the MIPS debug ports plus the UART TX.
interface debug_dump_engine_if #(
    parameter int LEN      = 32,
    parameter int LEN_DATA = 8,
    parameter int NB_ADDR  = 5
);
    logic [NB_ADDR-1:0]  addr;
    logic [LEN-1:0]      regs;
    logic [LEN-1:0]      mem_datos;
    logic                tx_start;
    logic [LEN_DATA-1:0] uart_data_out;
    logic                tx_done;

    modport master (
        output addr, tx_start, uart_data_out,
        input  regs, mem_datos, tx_done
    );

    modport slave (
        input  addr, tx_start, uart_data_out,
        output regs, mem_datos, tx_done
    );
endinterface

// File: rtl/debug_dump_engine.sv
// debug_dump_engine: on start, streams one framed snapshot of MIPS debug
// state to the UART transmitter, one byte per tx_start/tx_done handshake.
// Frame: HEADER, [PC, latches 0..NB_LATCHES-1], [regs 0..CANT_REGS-1],
//        [mem 0..CANT_MEM_DATOS-1], XOR checksum of all bytes after HEADER.
// Sections present depend on mode (00 all, 01 regs, 10 mem, 11 PC+latches).
// Words go out MSB byte first.
// Ports:
//   clk, reset (async, active-low)
//   start   : dump request, sampled in IDLE only (mode sampled with it)
//   abort   : synchronous cancel, back to IDLE without a done pulse
//   mode    : frame content select
//   pc      : current PC, snapshotted at frame start
//   latches : NB_LATCHES words, word i at [i*LEN +: LEN], snapshotted
//   busy    : high from accepted start until return to IDLE
//   done    : one-cycle pulse after the checksum byte completes
//   bus     : debug read port and UART TX handshake (master side)
module debug_dump_engine #(
    parameter int                  LEN            = 32,
    parameter int                  LEN_DATA       = 8,
    parameter int                  CANT_REGS      = 32,
    parameter int                  CANT_MEM_DATOS = 16,
    parameter int                  NB_LATCHES     = 4,
    parameter int                  NB_ADDR        = $clog2((CANT_REGS > CANT_MEM_DATOS) ? CANT_REGS : CANT_MEM_DATOS),
    parameter logic [LEN_DATA-1:0] HEADER         = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic [LEN-1:0]             pc,
    input  logic [NB_LATCHES*LEN-1:0]  latches,
    output logic                       busy,
    output logic                       done,
    debug_dump_engine_if.master        bus
);
    localparam int B     = LEN / LEN_DATA;
    localparam int BCW   = $clog2(B + 1);
    localparam int MAXN0 = (CANT_REGS > CANT_MEM_DATOS) ? CANT_REGS : CANT_MEM_DATOS;
    localparam int MAXN  = (MAXN0 > NB_LATCHES) ? MAXN0 : NB_LATCHES;
    localparam int IDXW  = $clog2(MAXN + 1);

    typedef enum logic [3:0] {
        IDLE, SNAP, SEND, WAIT_TX, RD_ADDR, RD_WAIT, CAPTURE, CKSUM, FINISH
    } state_t;

    typedef enum logic [2:0] {
        SEC_HDR, SEC_PC, SEC_LAT, SEC_REG, SEC_MEM, SEC_CKS
    } sec_t;

    state_t                    state;
    sec_t                      sec;
    sec_t                      sec_nxt;
    logic [1:0]                mode_q;
    logic [LEN-1:0]            pc_sh;
    logic [NB_LATCHES*LEN-1:0] lat_sh;
    logic [NB_LATCHES*LEN-1:0] lat_nxt;
    logic [LEN-1:0]            word_sr;
    logic [LEN_DATA-1:0]       cur_byte;
    logic [BCW-1:0]            byte_cnt;
    logic [IDXW-1:0]           idx;
    logic [LEN_DATA-1:0]       checksum;
    logic                      last_byte;
    logic                      sec_end;
    logic                      en_pl, en_rg, en_mm;

    assign cur_byte  = word_sr[LEN-1 -: LEN_DATA];
    // The latch shadow is consumed by shifting, so the next word is always
    // at the bottom and no variable part-select is needed.
    assign lat_nxt   = lat_sh >> LEN;
    assign last_byte = (byte_cnt == BCW'(B - 1));

    always_comb begin
        en_pl = (mode_q == 2'b00) || (mode_q == 2'b11);
        en_rg = (mode_q == 2'b00) || (mode_q == 2'b01);
        en_mm = (mode_q == 2'b00) || (mode_q == 2'b10);

        case (sec)
            SEC_HDR: sec_nxt = en_pl ? SEC_PC : (en_rg ? SEC_REG : (en_mm ? SEC_MEM : SEC_CKS));
            SEC_PC:  sec_nxt = SEC_LAT;
            SEC_LAT: sec_nxt = en_rg ? SEC_REG : (en_mm ? SEC_MEM : SEC_CKS);
            SEC_REG: sec_nxt = en_mm ? SEC_MEM : SEC_CKS;
            default: sec_nxt = SEC_CKS;
        endcase

        case (sec)
            SEC_HDR: sec_end = 1'b1;
            SEC_PC:  sec_end = 1'b1;
            SEC_LAT: sec_end = (idx == IDXW'(NB_LATCHES - 1));
            SEC_REG: sec_end = (idx == IDXW'(CANT_REGS - 1));
            SEC_MEM: sec_end = (idx == IDXW'(CANT_MEM_DATOS - 1));
            default: sec_end = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            sec               <= SEC_HDR;
            mode_q            <= '0;
            pc_sh             <= '0;
            lat_sh            <= '0;
            word_sr           <= '0;
            byte_cnt          <= '0;
            idx               <= '0;
            checksum          <= '0;
            bus.addr          <= '0;
            bus.tx_start      <= 1'b0;
            bus.uart_data_out <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            done         <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            mode_q   <= mode;
                            checksum <= '0;
                            busy     <= 1'b1;
                            state    <= SNAP;
                        end
                    end
                    SNAP: begin
                        pc_sh    <= pc;
                        lat_sh   <= latches;
                        word_sr  <= LEN'(HEADER) << (LEN - LEN_DATA);
                        sec      <= SEC_HDR;
                        byte_cnt <= '0;
                        idx      <= '0;
                        state    <= SEND;
                    end
                    SEND: begin
                        bus.uart_data_out <= cur_byte;
                        bus.tx_start      <= 1'b1;
                        if (sec != SEC_HDR && sec != SEC_CKS)
                            checksum <= checksum ^ cur_byte;
                        state <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        if (bus.tx_done) begin
                            if (sec == SEC_CKS) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= FINISH;
                            end else if (sec != SEC_HDR && !last_byte) begin
                                byte_cnt <= byte_cnt + 1'b1;
                                word_sr  <= word_sr << LEN_DATA;
                                state    <= SEND;
                            end else if (sec_end) begin
                                sec      <= sec_nxt;
                                idx      <= '0;
                                byte_cnt <= '0;
                                case (sec_nxt)
                                    SEC_PC: begin
                                        word_sr <= pc_sh;
                                        state   <= SEND;
                                    end
                                    SEC_LAT: begin
                                        word_sr <= lat_sh[LEN-1:0];
                                        state   <= SEND;
                                    end
                                    SEC_REG, SEC_MEM: begin
                                        bus.addr <= '0;
                                        state    <= RD_ADDR;
                                    end
                                    default: state <= CKSUM;
                                endcase
                            end else begin
                                idx      <= idx + 1'b1;
                                byte_cnt <= '0;
                                if (sec == SEC_LAT) begin
                                    lat_sh  <= lat_nxt;
                                    word_sr <= lat_nxt[LEN-1:0];
                                    state   <= SEND;
                                end else begin
                                    state <= RD_ADDR;
                                end
                            end
                        end
                    end
                    RD_ADDR: begin
                        bus.addr <= NB_ADDR'(idx);
                        state    <= RD_WAIT;
                    end
                    RD_WAIT: state <= CAPTURE;
                    CAPTURE: begin
                        word_sr <= (sec == SEC_REG) ? bus.regs : bus.mem_datos;
                        state   <= SEND;
                    end
                    CKSUM: begin
                        word_sr <= LEN'(checksum) << (LEN - LEN_DATA);
                        state   <= SEND;
                    end
                    FINISH: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
